// File: rtl/gearbox_n_to_1_fc_if.sv
// Valid-ready bundle for the n-to-1 splitting gearbox: a wide upstream word
// channel and a narrow downstream token channel.
interface gearbox_n_to_1_fc_if #(
    parameter int width = 8,
    parameter int n     = 2
);
    logic                 up_valid;
    logic                 up_ready;
    logic [n*width-1:0]   up_data;
    logic                 down_valid;
    logic [width-1:0]     down_data;
    logic                 down_last;
    logic                 down_ready;

    // The master supplies words and consumes tokens; the gearbox is the slave.
    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_last
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_last
    );
endinterface

// File: rtl/gearbox_n_to_1_fc.sv
// Splits each n*width upstream word into n narrow tokens, one per downstream
// handshake, with no bubbles between back-to-back words.
module gearbox_n_to_1_fc #(
    parameter int width     = 8,
    parameter int n         = 2,
    parameter bit msb_first = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gearbox_n_to_1_fc_if.slave   bus
);
    localparam int                 cnt_w    = $clog2(n);
    localparam logic [cnt_w-1:0]   last_cnt = cnt_w'(n - 1);

    typedef enum logic {
        EMPTY,
        SENDING
    } state_t;

    state_t             state, state_nxt;
    logic [cnt_w-1:0]   cnt, cnt_nxt;
    logic [n*width-1:0] word, word_nxt;

    logic               full;
    logic               at_last;
    logic               up_hs;
    logic               down_hs;
    logic [cnt_w-1:0]   sel;
    logic [width-1:0]   parts [n];

    assign full    = (state == SENDING);
    assign at_last = (cnt == last_cnt);

    // down_ready feeds up_ready combinationally so a new word can land on the
    // same edge the last part leaves, keeping the stream gap-free.
    assign bus.up_ready   = ~full | (bus.down_ready & at_last);
    assign bus.down_valid = full;
    assign bus.down_last  = full & at_last;

    assign up_hs   = bus.up_valid & bus.up_ready;
    assign down_hs = full & bus.down_ready;

    always_comb begin
        for (int i = 0; i < n; i++) begin
            parts[i] = word[i*width +: width];
        end
    end

    assign sel           = msb_first ? (last_cnt - cnt) : cnt;
    assign bus.down_data = parts[sel];

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        if (down_hs) begin
            if (at_last) begin
                cnt_nxt   = '0;
                state_nxt = EMPTY;
            end else begin
                cnt_nxt = cnt + cnt_w'(1);
            end
        end
        // A new word overrides the end-of-word clear on the same edge.
        if (up_hs) begin
            word_nxt  = bus.up_data;
            state_nxt = SENDING;
            cnt_nxt   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // the same pre-edge values; the word register is reset too because
    // down_data must read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            word  <= word_nxt;
        end
    end
endmodule
